// File: rtl/video_pkg.sv
// Shared 640x480@60 timing constants, sync polarity enum and runtime control struct
// for the video_* blocks.
package video_pkg;

  localparam int VGA_H_ACTIVE      = 640;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_SYNC        = 96;
  localparam int VGA_H_BACK_PORCH  = 48;
  localparam int VGA_V_ACTIVE      = 480;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_SYNC        = 2;
  localparam int VGA_V_BACK_PORCH  = 33;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic      enable;
    sync_pol_e hsync_pol;
    sync_pol_e vsync_pol;
    logic      dblscan;
    logic      scanline;
  } vga_ctrl_t;

  localparam vga_ctrl_t VGA_CTRL_RESET = '{
    enable:    1'b1,
    hsync_pol: SYNC_ACTIVE_LOW,
    vsync_pol: SYNC_ACTIVE_LOW,
    dblscan:   1'b0,
    scanline:  1'b0
  };

  function automatic int rgb_width(input int color_bits);
    return 3 * color_bits;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-latency shift register that aligns timing flags with the palette pipeline.
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_vga_timing.sv
// Parametrised VGA timing generator with frame-latched runtime config and registered pins.
// Scanline dimming of odd output lines is built only when VGA_SCANLINE_EN is defined.
module video_vga_timing
  import video_pkg::*;
#(
  parameter int COLOR_BITS     = 4,
  parameter int CW             = 11,
  parameter int PIPE_DELAY     = 2,
  parameter int PREFETCH_LINES = 1,
  parameter int H_ACTIVE       = VGA_H_ACTIVE,
  parameter int H_FRONT_PORCH  = VGA_H_FRONT_PORCH,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BACK_PORCH   = VGA_H_BACK_PORCH,
  parameter int V_ACTIVE       = VGA_V_ACTIVE,
  parameter int V_FRONT_PORCH  = VGA_V_FRONT_PORCH,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BACK_PORCH   = VGA_V_BACK_PORCH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [rgb_width(COLOR_BITS)-1:0]   palette_rgb_data,
  input  logic                               cfg_enable,
  input  logic                               cfg_hsync_pol,
  input  logic                               cfg_vsync_pol,
  input  logic                               cfg_dblscan,
  input  logic                               cfg_scanline,
  input  logic [rgb_width(COLOR_BITS)-1:0]   cfg_border,
  output logic [CW-1:0]                      render_x,
  output logic [CW-1:0]                      render_y,
  output logic                               start_of_screen,
  output logic                               start_of_line,
  output logic                               end_of_screen,
  output logic [7:0]                         frame_cnt,
  output logic [COLOR_BITS-1:0]              vga_r,
  output logic [COLOR_BITS-1:0]              vga_g,
  output logic [COLOR_BITS-1:0]              vga_b,
  output logic                               vga_hsync,
  output logic                               vga_vsync
);

  localparam int RGBW     = rgb_width(COLOR_BITS);
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
  // Prefetch line counted back from the last line, wrapping instead of underflowing.
  localparam int SOS_LINE = (((V_TOTAL - 1 - PREFETCH_LINES) % V_TOTAL) + V_TOTAL) % V_TOTAL;

  generate
    if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
      $error("video_vga_timing: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DELAY < 1) begin : g_bad_delay
      $error("video_vga_timing: PIPE_DELAY must be >= 1");
    end
    if (PREFETCH_LINES < 1 || PREFETCH_LINES > V_BACK_PORCH) begin : g_bad_prefetch
      $error("video_vga_timing: PREFETCH_LINES out of range");
    end
  endgenerate

  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [7:0]      frame_q, frame_d;
  vga_ctrl_t       ctrl_q, ctrl_d;
  logic [RGBW-1:0] border_q, border_d;
  logic [RGBW-1:0] rgb_q, rgb_d, rgb_src, rgb_dim;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            h_last, v_last, h_active, v_active;
  logic            hsync_raw, vsync_raw, active_raw;
  logic            hsync_dly, vsync_dly, active_dly;

  assign h_last    = (x_q == CW'(H_TOTAL - 1));
  assign v_last    = (y_q == CW'(V_TOTAL - 1));
  assign h_active  = (x_q < CW'(H_ACTIVE));
  assign v_active  = (y_q < CW'(V_ACTIVE));
  assign hsync_raw = (x_q >= CW'(HS_START)) && (x_q < CW'(HS_START + H_SYNC));
  assign vsync_raw = (y_q >= CW'(VS_START)) && (y_q < CW'(VS_START + V_SYNC));
  assign active_raw = h_active && v_active;

  assign start_of_line   = h_last;
  assign start_of_screen = h_last && (y_q == CW'(SOS_LINE));
  assign end_of_screen   = h_last && (y_q == CW'(V_ACTIVE - 1));
  assign frame_cnt       = frame_q;
  assign render_x        = h_active ? x_q : '0;
  assign render_y        = !v_active      ? '0 :
                           ctrl_q.dblscan ? {1'b0, y_q[CW-1:1]} : y_q;

  always_comb begin
    x_d      = h_last ? '0 : x_q + 1'b1;
    y_d      = y_q;
    frame_d  = frame_q;
    ctrl_d   = ctrl_q;
    border_d = border_q;
    if (h_last) begin
      if (v_last) begin
        y_d     = '0;
        frame_d = frame_q + 8'd1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
    // Config is only ever committed during vertical blanking, ahead of line 0.
    if (start_of_screen) begin
      ctrl_d.enable    = cfg_enable;
      ctrl_d.hsync_pol = sync_pol_e'(cfg_hsync_pol);
      ctrl_d.vsync_pol = sync_pol_e'(cfg_vsync_pol);
      ctrl_d.dblscan   = cfg_dblscan;
      ctrl_d.scanline  = cfg_scanline;
      border_d         = cfg_border;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      frame_q  <= '0;
      ctrl_q   <= VGA_CTRL_RESET;
      border_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      ctrl_q   <= ctrl_d;
      border_q <= border_d;
    end
  end

  video_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({hsync_raw, vsync_raw, active_raw}),
    .q_o ({hsync_dly, vsync_dly, active_dly})
  );

  assign rgb_src = ctrl_q.enable ? palette_rgb_data : border_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dim
      assign rgb_dim[gi*COLOR_BITS +: COLOR_BITS] = rgb_src[gi*COLOR_BITS +: COLOR_BITS] >> 1;
    end
  endgenerate

`ifdef VGA_SCANLINE_EN
  logic y0_dly;

  video_delay_line #(.WIDTH(1), .DEPTH(PIPE_DELAY)) u_y0_dly (
    .clk (clk),
    .rst (rst),
    .d_i (y_q[0]),
    .q_o (y0_dly)
  );

  always_comb begin
    rgb_d = '0;
    if (active_dly) rgb_d = (ctrl_q.scanline && y0_dly) ? rgb_dim : rgb_src;
  end
`else
  logic unused_scanline;
  assign unused_scanline = &{1'b0, ctrl_q.scanline, rgb_dim, 1'b0};

  always_comb begin
    rgb_d = '0;
    if (active_dly) rgb_d = rgb_src;
  end
`endif

  assign hsync_d = hsync_dly ^ ~ctrl_q.hsync_pol;
  assign vsync_d = vsync_dly ^ ~ctrl_q.vsync_pol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga_r     = rgb_q[RGBW-1 -: COLOR_BITS];
  assign vga_g     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_b     = rgb_q[COLOR_BITS-1:0];
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;

endmodule
